// File: rtl/npu_bus_pkg.sv
// Shared definitions for the NPU bus-side blocks: master FSM states,
// Wishbone word/select widths and the per-beat address step.
package npu_bus_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;
  localparam logic [WORD_W-1:0] ADR_INC = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_BUS,
    ST_RDATA,
    ST_DONE
  } wbmState_t;

  // Bursts are word-aligned; the byte offset of the start address is dropped.
  function automatic logic [WORD_W-1:0] alignAdr(input logic [WORD_W-1:0] adr);
    return {adr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wbm_beat_ctr.sv
// Beat down-counter and per-beat response timeout for the Wishbone master.
// o_lastBeat is high while the beat in flight is the final one of the burst.
module wbm_beat_ctr
  import npu_bus_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int TO_CYC = 255
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beatEnd,
  input  logic             i_toInc,
  input  logic             i_toClr,
  output logic             o_lastBeat,
  output logic             o_toHit
);

  localparam int TO_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);

  logic [LEN_W-1:0] r_beatCnt;
  logic [TO_W-1:0]  r_toCnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_beatCnt <= '0;
    end else if (i_load) begin
      r_beatCnt <= i_len;
    end else if (i_beatEnd && (r_beatCnt != '0)) begin
      r_beatCnt <= r_beatCnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_toCnt <= '0;
    end else if (i_toClr) begin
      r_toCnt <= '0;
    end else if (i_toInc) begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  // The counter holds the number of BUS cycles already spent, so the hit
  // flag is raised during the TO_CYC-th cycle without a response.
  assign o_lastBeat = (r_beatCnt == '0);
  assign o_toHit    = (r_toCnt == TO_W'(TO_CYC - 1));

endmodule

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one command (single or incrementing burst) at a
// time, with valid/ready streams for write data in and read data out.
module wb_master_port
  import npu_bus_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [WORD_W-1:0] cmd_adr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic              wdat_valid_i,
  input  logic [WORD_W-1:0] wdat_i,
  output logic              wdat_ready_o,
  output logic              rdat_valid_o,
  output logic [WORD_W-1:0] rdat_o,
  input  logic              rdat_ready_i,
  output logic              done_o,
  output logic              err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [WORD_W-1:0] wbm_adr_o,
  output logic [WORD_W-1:0] wbm_dat_o,
  input  logic [WORD_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i
);

  wbmState_t r_state;
  wbmState_t w_next;

  logic              r_we;
  logic [WORD_W-1:0] r_adr;
  logic [SEL_W-1:0]  r_sel;
  logic [WORD_W-1:0] r_wdat;
  logic [WORD_W-1:0] r_rdat;
  logic              r_err;
  logic              r_more;

  logic w_accept;
  logic w_wLatch;
  logic w_beatEnd;
  logic w_abort;
  logic w_lastBeat;
  logic w_toHit;

  wbm_beat_ctr #(
    .LEN_W (LEN_W),
    .TO_CYC(TO_CYC)
  ) u_beatCtr (
    .i_clk     (wb_clk_i),
    .i_rstN    (wb_rst_i),
    .i_load    (w_accept),
    .i_len     (cmd_len_i),
    .i_beatEnd (w_beatEnd),
    .i_toInc   (r_state == ST_BUS),
    .i_toClr   (w_beatEnd || w_abort),
    .o_lastBeat(w_lastBeat),
    .o_toHit   (w_toHit)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A bus error outranks an ack arriving in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_wLatch  = 1'b0;
    w_beatEnd = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_accept = 1'b1;
          w_next   = cmd_we_i ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA: begin
        if (wdat_valid_i) begin
          w_wLatch = 1'b1;
          w_next   = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_err_i || w_toHit) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else if (wbm_ack_i) begin
          w_beatEnd = 1'b1;
          if (!r_we) begin
            w_next = ST_RDATA;
          end else if (w_lastBeat) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_WDATA;
          end
        end
      end
      ST_RDATA: begin
        if (rdat_ready_i) begin
          w_next = r_more ? ST_BUS : ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // r_more remembers whether a read beat that already ended still has
  // successors, since the beat counter has moved on by the time RDATA decides.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_sel  <= '0;
      r_wdat <= '0;
      r_rdat <= '0;
      r_err  <= 1'b0;
      r_more <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we  <= cmd_we_i;
        r_adr <= alignAdr(cmd_adr_i);
        r_sel <= cmd_sel_i;
        r_err <= 1'b0;
      end
      if (w_wLatch) begin
        r_wdat <= wdat_i;
      end
      if (w_beatEnd) begin
        r_adr  <= r_adr + ADR_INC;
        r_more <= !w_lastBeat;
        if (!r_we) begin
          r_rdat <= wbm_dat_i;
        end
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cmd_ready_o  = (r_state == ST_IDLE);
  assign wdat_ready_o = (r_state == ST_WDATA);
  assign rdat_valid_o = (r_state == ST_RDATA);
  assign done_o       = (r_state == ST_DONE);
  assign wbm_stb_o    = (r_state == ST_BUS);
  assign wbm_cyc_o    = (r_state == ST_WDATA) || (r_state == ST_BUS) || (r_state == ST_RDATA);
  assign wbm_we_o     = r_we;
  assign wbm_sel_o    = r_sel;
  assign wbm_adr_o    = r_adr;
  assign wbm_dat_o    = r_wdat;
  assign rdat_o       = r_rdat;
  assign err_o        = r_err;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port with a behavioural Wishbone slave that
// supports wait states, error injection and a silent (never responding) mode.
module tb_wb_master_port;

   logic        clock = 1'b0;
   logic        rstN;
   logic        cmdValid, cmdReady, cmdWe;
   logic [31:0] cmdAdr;
   logic [3:0]  cmdLen, cmdSel;
   logic        wdatValid, wdatReady;
   logic [31:0] wdatIn;
   logic        rdatValid, rdatReady;
   logic [31:0] rdatOut;
   logic        doneOut, errOut;
   logic        wbCyc, wbStb, wbWe;
   logic [3:0]  wbSel;
   logic [31:0] wbAdr, wbDatO, wbDatI;
   logic        wbAck, wbErr;

   int assertCount = 0;
   int failCount = 0;
   int cycNum = 0;

   // slave model state
   int          slvWait = 0;
   int          slvErrBeat = -1;
   bit          slvMute = 0;
   bit          slvFixed = 0;
   int          beatNo = 0;
   int          waitCnt = 0;
   int          errCyc = 0;
   logic [31:0] sAdr [0:15];
   logic [31:0] sDat [0:15];
   logic [3:0]  sSel [0:15];
   logic        sWe  [0:15];

   // read sink and write source state
   int          rCnt = 0;
   int          stallIdx = -1;
   int          stallLen = 0;
   int          stallCnt = 0;
   int          stbInStall = 0;
   logic [31:0] rQ [0:15];
   logic [31:0] wQ [0:15];
   int          wIdx = 0;
   int          wCount = 0;

   // monitor state
   int cycCount = 0;
   int stbCount = 0;
   int doneCount = 0;
   int doneCyc = 0;
   int acceptCyc = 0;

   wb_master_port #(
      .LEN_W (4),
      .TO_CYC(8)
   ) dut (
      .wb_clk_i    (clock),
      .wb_rst_i    (rstN),
      .cmd_valid_i (cmdValid),
      .cmd_ready_o (cmdReady),
      .cmd_we_i    (cmdWe),
      .cmd_adr_i   (cmdAdr),
      .cmd_len_i   (cmdLen),
      .cmd_sel_i   (cmdSel),
      .wdat_valid_i(wdatValid),
      .wdat_i      (wdatIn),
      .wdat_ready_o(wdatReady),
      .rdat_valid_o(rdatValid),
      .rdat_o      (rdatOut),
      .rdat_ready_i(rdatReady),
      .done_o      (doneOut),
      .err_o       (errOut),
      .wbm_cyc_o   (wbCyc),
      .wbm_stb_o   (wbStb),
      .wbm_we_o    (wbWe),
      .wbm_sel_o   (wbSel),
      .wbm_adr_o   (wbAdr),
      .wbm_dat_o   (wbDatO),
      .wbm_dat_i   (wbDatI),
      .wbm_ack_i   (wbAck),
      .wbm_err_i   (wbErr)
   );

   always #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cycNum++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Offer one command as soon as the port is ready; returns #1 after the accept edge.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] len, input logic [3:0] sel);
      int n = 0;
      while (!cmdReady && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (n >= 50) checkOutput("cmdReadyWait", 32'd0, 32'd1);
      cmdValid = 1'b1;
      cmdWe = we;
      cmdAdr = adr;
      cmdLen = len;
      cmdSel = sel;
      @(posedge clock);
      #1;
      cmdValid = 1'b0;
      acceptCyc = cycNum;
   endtask

   // Returns at the falling edge inside the DONE cycle.
   task automatic waitDone(input int maxCyc);
      int n = 0;
      bit gotDone = 0;
      while (n < maxCyc) begin
         @(negedge clock);
         if (doneOut) begin
            gotDone = 1;
            break;
         end
         n++;
      end
      if (!gotDone) checkOutput("doneWait", 32'd0, 32'd1);
   endtask

   task automatic toIdlePhase();
      @(posedge clock);
      #1;
   endtask

   // Behavioural classic slave, responding on the falling edge.
   initial begin
      wbAck = 1'b0;
      wbErr = 1'b0;
      wbDatI = '0;
      forever begin
         @(negedge clock);
         wbAck = 1'b0;
         wbErr = 1'b0;
         if (wbCyc && wbStb) begin
            if (!slvMute && waitCnt >= slvWait) begin
               if (beatNo < 16) begin
                  sAdr[beatNo] = wbAdr;
                  sDat[beatNo] = wbDatO;
                  sSel[beatNo] = wbSel;
                  sWe[beatNo]  = wbWe;
               end
               if (beatNo == slvErrBeat) begin
                  wbErr = 1'b1;
                  errCyc = cycNum;
               end else begin
                  wbAck = 1'b1;
                  wbDatI = slvFixed ? 32'hDEADBEEF : (32'hC0DE0000 ^ wbAdr);
               end
               beatNo++;
               waitCnt = 0;
            end else begin
               waitCnt++;
            end
         end else begin
            waitCnt = 0;
         end
      end
   end

   // Read sink with an optional stall on one chosen beat.
   initial begin
      rdatReady = 1'b1;
      forever begin
         @(negedge clock);
         if (rdatValid && rCnt == stallIdx && stallCnt < stallLen) begin
            rdatReady = 1'b0;
            stallCnt++;
            if (wbStb) stbInStall++;
         end else begin
            rdatReady = 1'b1;
         end
         if (rdatValid && rdatReady) begin
            if (rCnt < 16) rQ[rCnt] = rdatOut;
            rCnt++;
         end
      end
   end

   // Write source: holds valid high while words remain in wQ.
   initial begin
      bit hs;
      wdatValid = 1'b0;
      wdatIn = '0;
      forever begin
         @(negedge clock);
         hs = wdatValid && wdatReady;
         @(posedge clock);
         #2;
         if (hs) wIdx++;
         if (wIdx < wCount) begin
            wdatValid = 1'b1;
            wdatIn = wQ[wIdx];
         end else begin
            wdatValid = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clock);
      if (wbCyc) cycCount++;
      if (wbStb) stbCount++;
      if (doneOut) begin
         doneCount++;
         doneCyc = cycNum;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] expAdr [0:3];
      logic [31:0] expRd  [0:3];
      int doneSnap;

      rstN = 1'b0;
      cmdValid = 1'b0;
      cmdWe = 1'b0;
      cmdAdr = '0;
      cmdLen = '0;
      cmdSel = '0;
      repeat (3) @(posedge clock);
      #1;

      // reset state
      checkOutput("rstCmdReady", {31'd0, cmdReady}, 32'd1);
      checkOutput("rstCtrl", {25'd0, wbCyc, wbStb, wbWe, doneOut, errOut, wdatReady, rdatValid}, 32'd0);
      checkOutput("rstAdr", wbAdr, 32'd0);
      checkOutput("rstDat", wbDatO, 32'd0);
      checkOutput("rstRdat", rdatOut, 32'd0);
      rstN = 1'b1;
      toIdlePhase();

      // single read, zero-wait slave
      slvFixed = 1;
      beatNo = 0;
      rCnt = 0;
      cycCount = 0;
      doneCount = 0;
      applyStimulus(1'b0, 32'h3000_0010, 4'd0, 4'hF);
      checkOutput("rd1FirstStb", {31'd0, wbStb}, 32'd1);
      waitDone(20);
      checkOutput("rd1Err", {31'd0, errOut}, 32'd0);
      checkOutput("rd1CycAtDone", {31'd0, wbCyc}, 32'd0);
      checkOutput("rd1AckToDone", doneCyc - acceptCyc, 32'd2);
      checkOutput("rd1Rdat", rdatOut, 32'hDEADBEEF);
      checkOutput("rd1Sink", rQ[0], 32'hDEADBEEF);
      checkOutput("rd1Adr", sAdr[0], 32'h3000_0010);
      checkOutput("rd1CycLen", cycCount, 32'd2);
      @(negedge clock);
      checkOutput("rd1DonePulse", {31'd0, doneOut}, 32'd0);
      toIdlePhase();
      checkOutput("rd1DoneCount", doneCount, 32'd1);
      slvFixed = 0;

      // write burst of 4, two wait states per beat
      for (int i = 0; i < 4; i++) wQ[i] = i + 1;
      wIdx = 0;
      wCount = 4;
      slvWait = 2;
      beatNo = 0;
      doneCount = 0;
      expAdr[0] = 32'h3000_0000;
      expAdr[1] = 32'h3000_0004;
      expAdr[2] = 32'h3000_0008;
      expAdr[3] = 32'h3000_000C;
      applyStimulus(1'b1, 32'h3000_0000, 4'd3, 4'b0110);
      checkOutput("wrFirstWdata", {30'd0, wdatReady, wbStb}, 32'd2);
      waitDone(100);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("wrAdr%0d", i), sAdr[i], expAdr[i]);
         checkOutput($sformatf("wrDat%0d", i), sDat[i], i + 1);
         checkOutput($sformatf("wrSel%0d", i), {28'd0, sSel[i]}, 32'h6);
         checkOutput($sformatf("wrWe%0d", i), {31'd0, sWe[i]}, 32'd1);
      end
      toIdlePhase();
      checkOutput("wrBeats", beatNo, 32'd4);
      checkOutput("wrConsumed", wIdx, 32'd4);
      checkOutput("wrDoneCount", doneCount, 32'd1);
      checkOutput("wrErr", {31'd0, errOut}, 32'd0);
      wCount = 0;
      slvWait = 0;

      // read burst of 4 with the sink stalled on beat 2
      beatNo = 0;
      rCnt = 0;
      stallIdx = 1;
      stallLen = 5;
      stallCnt = 0;
      stbInStall = 0;
      expRd[0] = 32'hF0DE_0100;
      expRd[1] = 32'hF0DE_0104;
      expRd[2] = 32'hF0DE_0108;
      expRd[3] = 32'hF0DE_010C;
      applyStimulus(1'b0, 32'h3000_0100, 4'd3, 4'hF);
      waitDone(100);
      checkOutput("rbCount", rCnt, 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rbData%0d", i), rQ[i], expRd[i]);
         checkOutput($sformatf("rbAdr%0d", i), sAdr[i], 32'h3000_0100 + 4 * i);
      end
      checkOutput("rbStallCycles", stallCnt, 32'd5);
      checkOutput("rbStbInStall", stbInStall, 32'd0);
      checkOutput("rbBeats", beatNo, 32'd4);
      stallIdx = -1;
      toIdlePhase();

      // bus error on beat 2 of a 4-beat read
      beatNo = 0;
      rCnt = 0;
      slvErrBeat = 1;
      doneCount = 0;
      applyStimulus(1'b0, 32'h3000_0200, 4'd3, 4'hF);
      waitDone(100);
      checkOutput("errFlag", {31'd0, errOut}, 32'd1);
      checkOutput("errCycLow", {31'd0, wbCyc}, 32'd0);
      checkOutput("errToDone", doneCyc - errCyc, 32'd1);
      repeat (4) toIdlePhase();
      checkOutput("errBeatsIssued", beatNo, 32'd2);
      checkOutput("errReadsOut", rCnt, 32'd1);
      checkOutput("errDoneCount", doneCount, 32'd1);
      slvErrBeat = -1;

      // silent slave hits the timeout
      slvMute = 1;
      stbCount = 0;
      applyStimulus(1'b0, 32'h3000_0300, 4'd0, 4'hF);
      waitDone(50);
      checkOutput("toFlag", {31'd0, errOut}, 32'd1);
      checkOutput("toStbCycles", stbCount, 32'd8);
      checkOutput("toAcceptToDone", doneCyc - acceptCyc, 32'd8);
      slvMute = 0;
      repeat (2) toIdlePhase();
      checkOutput("toErrHeld", {31'd0, errOut}, 32'd1);
      rCnt = 0;
      beatNo = 0;
      applyStimulus(1'b0, 32'h3000_0304, 4'd0, 4'hF);
      checkOutput("toErrCleared", {31'd0, errOut}, 32'd0);
      waitDone(20);
      checkOutput("toNextErr", {31'd0, errOut}, 32'd0);
      checkOutput("toNextData", rQ[0], 32'hF0DE_0304);
      toIdlePhase();

      // reset in the middle of a burst
      slvWait = 3;
      beatNo = 0;
      applyStimulus(1'b0, 32'h3000_0400, 4'd3, 4'hF);
      toIdlePhase();
      checkOutput("rsInBus", {31'd0, wbStb}, 32'd1);
      doneSnap = doneCount;
      rstN = 1'b0;
      toIdlePhase();
      checkOutput("rsCycStb", {30'd0, wbCyc, wbStb}, 32'd0);
      checkOutput("rsCmdReady", {31'd0, cmdReady}, 32'd1);
      rstN = 1'b1;
      repeat (3) toIdlePhase();
      checkOutput("rsNoDone", doneCount, doneSnap);
      checkOutput("rsNoAck", beatNo, 32'd0);
      slvWait = 0;

      // address wrap across the top of the space
      beatNo = 0;
      rCnt = 0;
      applyStimulus(1'b0, 32'hFFFF_FFFC, 4'd1, 4'hF);
      waitDone(40);
      checkOutput("wrapAdr0", sAdr[0], 32'hFFFF_FFFC);
      checkOutput("wrapAdr1", sAdr[1], 32'h0000_0000);
      checkOutput("wrapData0", rQ[0], 32'h3F21_FFFC);
      checkOutput("wrapData1", rQ[1], 32'hC0DE_0000);
      toIdlePhase();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
